// File: rtl/ccd_frame_packer_pkg.sv
// ccd_frame_packer_pkg: packet constants, Gray-coded FSM states and helpers shared by the packer and host tools.
package ccd_frame_packer_pkg;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam logic [7:0] END_BYTE_DEF  = 8'h5A;
   // Packet layout: [SYNC][SEQ] payload... [END|ovf][LINES_LO][LINES_HI]
   localparam int OFS_SYNC = 0;
   localparam int OFS_SEQ  = 1;
   localparam int HDR_LEN  = 2;
   localparam int TRL_LEN  = 3;
   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      HDR0   = 3'b001,
      HDR1   = 3'b011,
      STREAM = 3'b010,
      TRL0   = 3'b110,
      TRL1   = 3'b111,
      TRL2   = 3'b101,
      DRAIN  = 3'b100
   } state_t;
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return &v ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/ccd_frame_packer_if.sv
// ccd_frame_packer_if: readout byte stream in, tx_fifo write port out, plus drop counter for debug.
interface ccd_frame_packer_if;
   logic       frame_start;
   logic       frame_end;
   logic       line_end;
   logic       sample_valid;
   logic [7:0] sample_data;
   logic       tx_wfull;
   logic [7:0] tx_wdata;
   logic       tx_winc;
   logic [7:0] drop_count;
   modport master (
      output frame_start, frame_end, line_end, sample_valid, sample_data, tx_wfull,
      input  tx_wdata, tx_winc, drop_count
   );
   modport slave (
      input  frame_start, frame_end, line_end, sample_valid, sample_data, tx_wfull,
      output tx_wdata, tx_winc, drop_count
   );
endinterface

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: single-clock first-word-fall-through byte FIFO with wrap-bit pointers.
module sync_byte_fifo #(
   parameter int AW = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);
   logic [7:0] mem [2**AW];
   logic [AW:0] wp, rp;
   assign empty = wp == rp;
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign dout  = mem[rp[AW-1:0]];
   always_ff @(posedge clk)
      if (push) mem[wp[AW-1:0]] <= din;
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + (AW+1)'(1);
         if (pop)  rp <= rp + (AW+1)'(1);
      end
   end
endmodule

// File: rtl/ccd_frame_packer.sv
// ccd_frame_packer: frames a CCD readout into header/payload/trailer and buffers it toward tx_fifo.
module ccd_frame_packer
   import ccd_frame_packer_pkg::*;
#(
   parameter int         BUF_AW    = 4,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter logic [7:0] END_BYTE  = END_BYTE_DEF
) (
   input  logic                clk,
   input  logic                rst,
   ccd_frame_packer_if.slave   bus,
   output logic                busy,
   output logic                overflow
);
   state_t      state, state_n;
   logic [7:0]  seq, drops, din, dout;
   logic [15:0] lines;
   logic        ovf, push, pop, empty, full, room, drop, start;
   sync_byte_fifo #(.AW(BUF_AW)) u_fifo (
      .clk(clk), .rst(rst), .push(push), .pop(pop),
      .din(din), .dout(dout), .empty(empty), .full(full)
   );
   assign bus.tx_winc    = pop;
   assign bus.tx_wdata   = dout;
   assign bus.drop_count = drops;
   assign busy           = state != IDLE;
   assign overflow       = ovf;
   // A full buffer still has room when the head leaves this same cycle.
   always_comb begin
      pop     = !empty && !bus.tx_wfull;
      room    = !full || pop;
      start   = state == IDLE && bus.frame_start;
      state_n = state;
      push    = 1'b0;
      din     = bus.sample_data;
      case (state)
         IDLE:    state_n = bus.frame_start ? HDR0 : IDLE;
         HDR0:    begin push = room; din = SYNC_BYTE; state_n = room ? HDR1 : HDR0; end
         HDR1:    begin push = room; din = seq; state_n = room ? STREAM : HDR1; end
         STREAM:  begin push = bus.sample_valid && room; state_n = bus.frame_end ? TRL0 : STREAM; end
         TRL0:    begin push = room; din = ovf ? (END_BYTE | 8'h01) : END_BYTE; state_n = room ? TRL1 : TRL0; end
         TRL1:    begin push = room; din = lines[7:0]; state_n = room ? TRL2 : TRL1; end
         TRL2:    begin push = room; din = lines[15:8]; state_n = room ? DRAIN : TRL2; end
         DRAIN:   state_n = empty ? IDLE : DRAIN;
         default: state_n = IDLE;
      endcase
      drop = bus.sample_valid && !(state == STREAM && room);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         seq   <= '0;
         lines <= '0;
         drops <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         ovf   <= drop || (ovf && !start);
         drops <= start ? 8'(drop) : drops + 8'(drop && !(&drops));
         lines <= start ? 16'd0 : (state == STREAM && bus.line_end) ? sat_inc16(lines) : lines;
         if (state == TRL2 && room) seq <= seq + 8'd1;
      end
   end
endmodule
